// File: rtl/seq_share_ctrl.sv
// Round-robin owner of a shared 3-phase sequencer: grants BURST full sequences per owner,
// drives pause/restart, and aborts owners that drop req, stall too long, or see an illegal state.
//
// state | meaning
// IDLE  | no owner; sequencer held in restart (FIRST); arbitrating req
// RUN   | owner granted; sequencer runs, owner's hold pauses it
module seq_share_ctrl #(
    parameter int N        = 4,
    parameter int BURST    = 2,
    parameter int MAX_HOLD = 8,
    localparam int OW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [N-1:0]  req_i,
    input  logic [N-1:0]  hold_i,
    input  logic [1:0]    seq_state_i,
    input  logic          seq_terminal_i,
    output logic          seq_pause_o,
    output logic          seq_restart_o,
    output logic [N-1:0]  grant_o,
    output logic [OW-1:0] owner_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          abort_o
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] ptr_q, ptr_d;
    logic [3:0]    burst_q, burst_d;
    logic [7:0]    hold_q, hold_d;
    logic          done_q, done_d;
    logic          abort_q, abort_d;

    logic          found;
    logic [OW-1:0] winner;
    int            idx;
    logic [OW-1:0] ptr_next;
    logic          own_req, own_hold, abort_cond;

    // First requester at or above the pointer, wrapping modulo N.
    always_comb begin
        found  = 1'b0;
        winner = ptr_q;
        idx    = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N) idx = idx - N;
            if (!found && req_i[OW'(idx)]) begin
                found  = 1'b1;
                winner = OW'(idx);
            end
        end
    end

    assign own_req    = req_i[owner_q];
    assign own_hold   = hold_i[owner_q];
    assign ptr_next   = (owner_q == OW'(N - 1)) ? '0 : owner_q + OW'(1);
    assign abort_cond = !own_req || (seq_state_i == 2'b00) ||
                        (own_hold && (hold_q == 8'(MAX_HOLD - 1)));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        burst_d = burst_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = RUN;
                    grant_d = {{(N-1){1'b0}}, 1'b1} << winner;
                    owner_d = winner;
                    burst_d = '0;
                    hold_d  = '0;
                end
            end
            RUN: begin
                if (abort_cond) begin
                    state_d = IDLE;
                    grant_d = '0;
                    abort_d = 1'b1;
                    ptr_d   = ptr_next;
                end else begin
                    // A terminal seen while paused does not count as a completed sequence.
                    if (seq_terminal_i && !own_hold) begin
                        if (burst_q == 4'(BURST - 1)) begin
                            state_d = IDLE;
                            grant_d = '0;
                            done_d  = 1'b1;
                            ptr_d   = ptr_next;
                        end else begin
                            burst_d = burst_q + 4'd1;
                        end
                    end
                    hold_d = own_hold ? hold_q + 8'd1 : 8'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            burst_q <= '0;
            hold_q  <= '0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            burst_q <= burst_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    assign seq_restart_o = (state_q != RUN);
    assign seq_pause_o   = (state_q == RUN) && own_hold;
    assign busy_o        = (state_q == RUN);
    assign grant_o       = grant_q;
    assign owner_o       = owner_q;
    assign done_o        = done_q;
    assign abort_o       = abort_q;

endmodule

// File: tb/tb_seq_share_ctrl.sv
// Directed bench for seq_share_ctrl with a behavioural 3-phase sequencer attached.
module tb_seq_share_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] hold = 4'b0000;
    logic       force_ill = 1'b0;
    logic [1:0] seq_q = 2'b11;
    logic [1:0] seq_state;
    logic       seq_terminal;
    logic       seq_pause, seq_restart, busy, done, abort;
    logic [3:0] grant;
    logic [1:0] owner;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_share_ctrl #(.N(4), .BURST(2), .MAX_HOLD(8)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .hold_i(hold),
        .seq_state_i(seq_state), .seq_terminal_i(seq_terminal),
        .seq_pause_o(seq_pause), .seq_restart_o(seq_restart),
        .grant_o(grant), .owner_o(owner), .busy_o(busy),
        .done_o(done), .abort_o(abort)
    );

    // Sequencer: restart forces FIRST, pause freezes, otherwise 11 -> 01 -> 10 -> 11.
    always @(posedge clk) begin
        if (seq_restart)    seq_q <= 2'b11;
        else if (seq_pause) seq_q <= seq_q;
        else case (seq_q)
            2'b11:   seq_q <= 2'b01;
            2'b01:   seq_q <= 2'b10;
            default: seq_q <= 2'b11;
        endcase
    end
    assign seq_state    = force_ill ? 2'b00 : seq_q;
    assign seq_terminal = (seq_state == 2'b10);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered on the first RUN cycle of a grant; leaves on the first cycle of the next grant.
    task automatic grant_cycle(input logic [3:0] exp_g);
        logic [1:0] tbl [6];
        tbl = '{2'b11, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10};
        for (int k = 0; k < 6; k++) begin
            check("run_grant", 8'(grant), 8'(exp_g));
            check("run_state", 8'(seq_state), 8'(tbl[k]));
            check("run_nodone", 8'(done), 8'h00);
            tick();
        end
        check("idle_done", 8'(done), 8'h01);
        check("idle_abort", 8'(abort), 8'h00);
        check("idle_grant", 8'(grant), 8'h00);
        check("idle_restart", 8'(seq_restart), 8'h01);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] hv [9];
        logic [1:0] sv [9];
        logic       pv [9];

        // Reset with all requesting
        rst = 1'b0; req = 4'b1111;
        tick(); tick();
        check("rst_grant", 8'(grant), 8'h00);
        check("rst_busy", 8'(busy), 8'h00);
        check("rst_restart", 8'(seq_restart), 8'h01);
        check("rst_pause", 8'(seq_pause), 8'h00);
        check("rst_done", 8'(done), 8'h00);
        check("rst_abort", 8'(abort), 8'h00);
        check("rst_owner", 8'(owner), 8'h00);
        rst = 1'b1;
        tick();
        check("first_grant", 8'(grant), 8'h01);
        check("first_busy", 8'(busy), 8'h01);

        // Fairness: round robin with done after each grant
        grant_cycle(4'b0001);
        grant_cycle(4'b0010);
        grant_cycle(4'b0100);
        check("rr_owner", 8'(owner), 8'h03);
        grant_cycle(4'b1000);
        check("rr_wrap", 8'(grant), 8'h01);

        // Single requester, re-granted after one IDLE cycle
        rst = 1'b0; tick(); tick();
        req = 4'b0100; rst = 1'b1;
        tick();
        check("single_grant", 8'(grant), 8'h04);
        check("single_owner", 8'(owner), 8'h02);
        grant_cycle(4'b0100);
        check("single_regrant", 8'(grant), 8'h04);

        // Pause for 3 cycles in SECOND; non-owner holds ignored
        hv = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b1011, 4'b1011, 4'b0000, 4'b0000};
        sv = '{2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10};
        pv = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 9; k++) begin
            hold = hv[k];
            #1;
            check("pz_state", 8'(seq_state), 8'(sv[k]));
            check("pz_pause", 8'(seq_pause), 8'(pv[k]));
            check("pz_noabort", 8'(abort), 8'h00);
            check("pz_nodone", 8'(done), 8'h00);
            tick();
        end
        hold = 4'b0000;
        check("pz_done", 8'(done), 8'h01);
        check("pz_idle", 8'(grant), 8'h00);
        tick();
        check("pz_regrant", 8'(grant), 8'h04);

        // Pause timeout: abort after the 8th paused cycle
        req = 4'b1111; hold = 4'b0100;
        for (int k = 0; k < 7; k++) tick();
        check("to_grant8", 8'(grant), 8'h04);
        check("to_noabort8", 8'(abort), 8'h00);
        check("to_state8", 8'(seq_state), 8'h03);
        tick();
        hold = 4'b0000;
        check("to_abort", 8'(abort), 8'h01);
        check("to_done", 8'(done), 8'h00);
        check("to_grant0", 8'(grant), 8'h00);
        check("to_restart", 8'(seq_restart), 8'h01);
        tick();
        check("to_next", 8'(grant), 8'h08);
        check("to_abort_1cyc", 8'(abort), 8'h00);
        grant_cycle(4'b1000);
        check("to_not_regrant", 8'(grant), 8'h01);

        // Illegal sequencer state
        tick();
        force_ill = 1'b1;
        #1;
        check("ill_busy", 8'(busy), 8'h01);
        tick();
        force_ill = 1'b0;
        check("ill_abort", 8'(abort), 8'h01);
        check("ill_grant", 8'(grant), 8'h00);
        tick();
        check("ill_next", 8'(grant), 8'h02);

        // Owner drops req in final terminal cycle
        for (int k = 0; k < 5; k++) tick();
        check("drop_term", 8'(seq_terminal), 8'h01);
        req = 4'b1101;
        tick();
        check("drop_abort", 8'(abort), 8'h01);
        check("drop_nodone", 8'(done), 8'h00);
        tick();
        check("drop_next", 8'(grant), 8'h04);
        check("drop_pulse", 8'(abort), 8'h00);

        // Reset mid-RUN: no pulse
        tick();
        rst = 1'b0;
        tick();
        check("mrst_grant", 8'(grant), 8'h00);
        check("mrst_busy", 8'(busy), 8'h00);
        check("mrst_restart", 8'(seq_restart), 8'h01);
        check("mrst_done", 8'(done), 8'h00);
        check("mrst_abort", 8'(abort), 8'h00);
        tick();
        check("mrst_done2", 8'(done), 8'h00);
        check("mrst_abort2", 8'(abort), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
